// File: rtl/cache_pkg.sv
// Shared definitions for the tag-lookup controller.
// Address split: {tag[21:0], idx[5:0], offset[3:0]} for a 32-bit byte address.
// The package holds the controller state encoding and the helpers that
// slice an address into its tag and set index.
package cache_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 6;
  localparam int OFF_W  = 4;
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2,
    UPDATE = 2'd3
  } state_t;

  function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] get_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Bundle of every non-clock signal around the tag-lookup controller.
// Groups: request (req_*), response (resp_*), line-fill handshake
// (refill_*), flush, tag SRAM pins (tag_*) and the statistics counters.
// Modports:
//   master - requester, line-fill unit and tag SRAM side
//   slave  - the controller itself
interface tag_lookup_ctrl_if
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic [IDX_W-1:0]  resp_index;
  logic              refill_req;
  logic [ADDR_W-1:0] refill_addr;
  logic              refill_done;
  logic              flush;
  logic              tag_cs;
  logic              tag_web;
  logic              tag_oe;
  logic [IDX_W-1:0]  tag_addr;
  logic [TAG_W-1:0]  tag_di;
  logic [TAG_W-1:0]  tag_do;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  modport master (
    output req_valid, req_addr, refill_done, flush, tag_do,
    input  req_ready, resp_valid, resp_hit, resp_index, refill_req,
           refill_addr, tag_cs, tag_web, tag_oe, tag_addr, tag_di,
           hit_cnt, miss_cnt
  );

  modport slave (
    input  req_valid, req_addr, refill_done, flush, tag_do,
    output req_ready, resp_valid, resp_hit, resp_index, refill_req,
           refill_addr, tag_cs, tag_web, tag_oe, tag_addr, tag_di,
           hit_cnt, miss_cnt
  );

endinterface

// File: rtl/tag_lookup_ctrl_valid_bit_array.sv
// Per-set valid bits, one flop per cache set.
// Ports:
//   clk, rst     - clock, async active-high clear of all bits
//   i_flush      - synchronous clear of every bit (takes priority over set)
//   i_set_en     - set the bit addressed by i_set_idx
//   i_rd_idx     - combinational read index
//   o_rd_valid   - valid bit of set i_rd_idx
module valid_bit_array
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_set_en,
  input  logic [IDX_W-1:0] i_set_idx,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid
);

  logic [2**IDX_W-1:0] r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_set_en) begin
      r_valid[i_set_idx] <= 1'b1;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Direct-mapped cache tag-lookup controller in front of a 64 x 22 tag SRAM.
// A request is accepted in IDLE while the SRAM read is launched in the same
// cycle; LOOKUP compares the returned tag against the captured one. A miss
// raises a registered refill request to the line-fill unit, and after
// refill_done the new tag is written back in UPDATE.
// Ports:
//   clk, rst - clock, async active-high reset
//   bus      - tag_lookup_ctrl_if.slave (request/response, refill handshake,
//              flush, tag SRAM pins, hit/miss counters)
module tag_lookup_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  tag_lookup_ctrl_if.slave   bus
);

  state_t            r_state;
  state_t            w_next;
  logic [TAG_W-1:0]  r_cap_tag;
  logic [IDX_W-1:0]  r_cap_idx;
  logic              r_refill_req;
  logic [ADDR_W-1:0] r_refill_addr;
  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;
  logic              w_set_valid;
  logic              w_hit;
  logic              w_accept;
  logic              w_flush_clr;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign w_flush_clr = (r_state == IDLE) && bus.flush;
  assign w_accept    = (r_state == IDLE) && !bus.flush && bus.req_valid;
  assign w_hit       = (r_state == LOOKUP) && w_set_valid && (bus.tag_do == r_cap_tag);

  valid_bit_array u_valid (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush_clr),
    .i_set_en   (r_state == UPDATE),
    .i_set_idx  (r_cap_idx),
    .i_rd_idx   (r_cap_idx),
    .o_rd_valid (w_set_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_hit   = 1'b0;
    bus.resp_index = '0;
    bus.tag_cs     = 1'b0;
    bus.tag_web    = 1'b1;
    bus.tag_oe     = 1'b0;
    bus.tag_addr   = '0;
    bus.tag_di     = '0;
    case (r_state)
      IDLE: begin
        bus.req_ready = !bus.flush;
        if (w_accept) begin
          // Read launched in the accept cycle so tag_do is ready in LOOKUP.
          bus.tag_cs   = 1'b1;
          bus.tag_addr = get_idx(bus.req_addr);
          w_next       = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.tag_oe = 1'b1;
        if (w_hit) begin
          bus.resp_valid = 1'b1;
          bus.resp_hit   = 1'b1;
          bus.resp_index = r_cap_idx;
          w_next         = IDLE;
        end else begin
          w_next = REFILL;
        end
      end
      REFILL: begin
        if (bus.refill_done) w_next = UPDATE;
      end
      UPDATE: begin
        bus.tag_cs     = 1'b1;
        bus.tag_web    = 1'b0;
        bus.tag_addr   = r_cap_idx;
        bus.tag_di     = r_cap_tag;
        bus.resp_valid = 1'b1;
        bus.resp_index = r_cap_idx;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // State is already IDLE during reset; only the IDLE-cycle outputs
    // need masking so nothing toggles while rst is high.
    if (rst) begin
      bus.req_ready = 1'b0;
      bus.tag_cs    = 1'b0;
      bus.tag_addr  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_tag     <= '0;
      r_cap_idx     <= '0;
      r_refill_req  <= 1'b0;
      r_refill_addr <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_cap_tag <= get_tag(bus.req_addr);
        r_cap_idx <= get_idx(bus.req_addr);
      end
      if ((r_state == LOOKUP) && !w_hit) begin
        r_refill_req  <= 1'b1;
        r_refill_addr <= {r_cap_tag, r_cap_idx, {OFF_W{1'b0}}};
      end else if ((r_state == REFILL) && bus.refill_done) begin
        r_refill_req <= 1'b0;
      end
      if (w_hit)              r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (r_state == UPDATE)  r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign bus.refill_req  = r_refill_req;
  assign bus.refill_addr = r_refill_addr;
  assign bus.hit_cnt     = r_hit_cnt;
  assign bus.miss_cnt    = r_miss_cnt;

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
// Bench for tag_lookup_ctrl: behavioural tag SRAM, line-fill responder,
// reference model of valid bits/tags/counters and a response scoreboard.
module tb_tag_lookup_ctrl;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tag_lookup_ctrl_if #(.CNT_W(16)) bus ();

  tag_lookup_ctrl #(.CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Tag SRAM: synchronous write, read data valid the cycle after the read.
  logic [TAG_W-1:0] mem [64];
  always @(posedge clk) begin
    if (bus.tag_cs) begin
      if (!bus.tag_web) mem[bus.tag_addr] <= bus.tag_di;
      else              bus.tag_do <= mem[bus.tag_addr];
    end
  end

  // Reference model
  logic             mvalid [64];
  logic [TAG_W-1:0] mtag   [64];
  logic [15:0]      mhit;
  logic [15:0]      mmiss;
  logic [6:0]       exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [15:0] msat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    mhit  = '0;
    mmiss = '0;
    exp_q.delete();
  endtask

  task automatic lookup(input logic [31:0] a);
    logic [TAG_W-1:0] t;
    logic [IDX_W-1:0] ix;
    logic             eh;
    logic [6:0]       e;
    int               rcyc;
    bit               done;
    t  = a[31:10];
    ix = a[9:4];
    eh = mvalid[ix] && (mtag[ix] == t);
    exp_q.push_back({eh, ix});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    #1 check("req_ready", bus.req_ready, 1);
    check("rd_cs", bus.tag_cs, 1);
    check("rd_addr", bus.tag_addr, ix);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    done = 0;
    rcyc = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      bus.refill_done = 1'b0;
      if (bus.refill_req) begin
        rcyc++;
        check("refill_addr", bus.refill_addr, {a[31:4], 4'b0});
        if (rcyc == 5) bus.refill_done = 1'b1;
      end
      if (bus.resp_valid) begin
        e = exp_q.pop_front();
        check("resp_hit", bus.resp_hit, e[6]);
        check("resp_index", bus.resp_index, e[5:0]);
        if (eh) check("hit_latency", k, 0);
        else    check("refill_cycles", rcyc, 5);
        done = 1;
      end
    end
    bus.refill_done = 1'b0;
    if (!done) check("resp_timeout", 0, 1);
    if (eh) begin
      mhit = msat(mhit);
    end else begin
      mvalid[ix] = 1'b1;
      mtag[ix]   = t;
      mmiss      = msat(mmiss);
    end
    @(negedge clk);
    check("hit_cnt", bus.hit_cnt, mhit);
    check("miss_cnt", bus.miss_cnt, mmiss);
    check("refill_idle", bus.refill_req, 0);
    if (!eh) check("sram_tag", mem[ix], t);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.refill_done = 1'b0;
    bus.flush       = 1'b0;
    bus.tag_do      = '0;
    model_reset();

    // Outputs while reset is held, with a request pending
    @(negedge clk);
    bus.req_valid = 1'b1;
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_cs", bus.tag_cs, 0);
    check("rst_web", bus.tag_web, 1);
    check("rst_oe", bus.tag_oe, 0);
    check("rst_resp", bus.resp_valid, 0);
    check("rst_refill", bus.refill_req, 0);
    check("rst_refill_addr", bus.refill_addr, 0);
    check("rst_hit_cnt", bus.hit_cnt, 0);
    check("rst_miss_cnt", bus.miss_cnt, 0);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Cold miss, warm hit, conflict and replacement
    lookup(32'h0000_1230);
    lookup(32'h0000_1238);
    lookup(32'h0040_1230);
    lookup(32'h0000_1230);
    lookup(32'h0000_5670);

    // Flush wins over a simultaneous request
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1230;
    #1 check("flush_ready", bus.req_ready, 0);
    check("flush_cs", bus.tag_cs, 0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    #1 check("flush_no_resp", bus.resp_valid, 0);
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
    lookup(32'h0000_1230);
    lookup(32'h0040_1230);

    // Saturating hit counter and spurious refill_done in IDLE
    @(negedge clk);
    force dut.r_hit_cnt = 16'hFFFE;
    #1 release dut.r_hit_cnt;
    mhit = 16'hFFFE;
    for (int i = 0; i < 3; i++) lookup(32'h0040_1234);
    check("hit_sat", bus.hit_cnt, 16'hFFFF);
    @(negedge clk);
    bus.refill_done = 1'b1;
    #1 check("spur_resp", bus.resp_valid, 0);
    @(negedge clk);
    bus.refill_done = 1'b0;
    #1 check("spur_resp2", bus.resp_valid, 0);
    check("spur_refill", bus.refill_req, 0);
    check("spur_ready", bus.req_ready, 1);

    // Reset while a refill is outstanding
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0123_4560;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.refill_req) seen = 1;
    end
    check("mid_refill_seen", seen, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_refill", bus.refill_req, 0);
    check("mid_rst_resp", bus.resp_valid, 0);
    check("mid_rst_cs", bus.tag_cs, 0);
    check("mid_rst_hit_cnt", bus.hit_cnt, 0);
    check("mid_rst_miss_cnt", bus.miss_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    lookup(32'h0040_1230);
    lookup(32'h0040_1230);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
